logic_config_loader: RTL
========================

# logic_config_loader

Bus initiator that programs the configurable-logic peripheral from a byte stream (e.g. UART RX), so a logic configuration can be loaded without CPU register pokes. It accepts 40 configuration bytes (8 gates × 5 registers), issues one picosoc-style `valid`/`ready` write per byte at the matching gate register address, then issues one read to capture the peripheral's status word. It sits between a byte source and the peripheral's bus port, muxed with the CPU bus at the SoC level.

## Interface
- `BASE_ADDR`, 16'h0000: added to every generated address.
- `NUM_GATES`, 8: gates to program.
- `REGS_PER_GATE`, 5: registers per gate (4 input selects, 1 function select).

- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a load when idle.
- `s_data`  in  8  stream byte.
- `s_valid`  in  1  stream byte valid.
- `s_ready`  out  1  loader accepts byte.
- `mem_valid`  out  1  bus request.
- `mem_ready`  in  1  responder completion.
- `mem_addr`  out  16  bus address.
- `mem_wdata`  out  32  write data, `{24'b0, byte}`.
- `mem_wstrb`  out  4  4'b0001 for write, 4'b0000 for read.
- `mem_rdata`  in  32  read data.
- `busy`  out  1  load in progress.
- `done`  out  1  level; set at load end, cleared by next accepted `start`.
- `err`  out  1  level; checksum failure (macro only), cleared by accepted `start`.
- `snapshot`  out  32  `mem_rdata` captured by the final read.

## Operation
- States: IDLE, GET_BYTE, WRITE, (CHECK), READ, FINISH.
- IDLE: `start` → GET_BYTE, clear `done`/`err`, zero counters `gate` (3 b) and `reg` (3 b). `start` outside IDLE is ignored.
- GET_BYTE: `s_ready`=1; on `s_valid && s_ready` latch byte, → WRITE.
- WRITE: `mem_valid`=1, `mem_addr` = `BASE_ADDR + {5'b0, gate, 5'b0, reg}`, `mem_wstrb`=4'b0001. Address, data, and strobe are held stable until `mem_ready` is sampled high. On `mem_ready`, advance: `reg` 0..4, wrap 4→0 with `gate`++. After gate 7 reg 4 → CHECK (macro) or READ; otherwise → GET_BYTE.
- READ: `mem_valid`=1, `mem_addr`=`BASE_ADDR`, `mem_wstrb`=0; on `mem_ready` latch `snapshot` ← `mem_rdata`, → FINISH.
- FINISH: `done`←1, → IDLE.
- `mem_valid` is deasserted for at least one cycle after every sampled `mem_ready`; this is required because the responder re-arms only on `valid && !ready`.
- `mem_ready` outside WRITE/READ is ignored.

## Timing
- All outputs registered. Reset values: `s_ready`=0, `mem_valid`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `busy`=0, `done`=0, `err`=0, `snapshot`=0.
- Byte accepted at cycle T → `mem_valid` high at T+1. With a responder returning `ready` one cycle after `valid` (at T+2), `mem_valid` is low and `s_ready` is high at T+3. Steady-state throughput is 1 byte per 3 cycles.
- Full load with an ideal source and single-cycle responder: 40×3 cycles + read (2) + FINISH (1).
- Responder latency is unbounded; there is no timeout.
- `resetn` low mid-transaction drops `mem_valid` immediately and discards the partial load. The peripheral's config is left partially written; software reloads it.
- `busy` is high from the cycle after an accepted `start` through FINISH.

## Configuration
- `LOGIC_LOADER_CHECKSUM_EN` defined:
  - After the 40th write, CHECK takes one more byte from the stream (`s_ready`=1).
  - That byte is compared against the XOR of the 40 config bytes. Mismatch sets `err`=1.
  - READ and FINISH proceed regardless.
- Undefined: the CHECK state, the accumulator and `err` logic are absent; `err` is tied 0; exactly 40 bytes are consumed.

## Structure
- Package `logic_loader_pkg`:
  - state enum;
  - `NUM_GATES`, `REGS_PER_GATE`;
  - `WSTRB_BYTE0`=4'b0001;
  - address field offsets (gate at bit 8, reg at bit 0).
- One sub-module, `mem_initiator`: it holds a single request stable on `valid` until `ready`, and enforces the post-`ready` idle cycle. The FSM drives it with a request pulse plus addr/wdata/wstrb, and gets back a completion pulse and the captured rdata.

## Test plan
- Bytes 0x00..0x27 streamed back-to-back, 1-cycle responder:
  - 40 writes at 0x0000–0x0004, 0x0100–0x0104, … 0x0700–0x0704, with `wdata[7:0]` equal to the byte;
  - one read at 0x0000; `snapshot` equals the responder's rdata;
  - `done`=1 after 123 cycles ±1.
- Source inserts 0–7 idle cycles between bytes at random: identical write sequence, no duplicated or dropped write.
- Responder returns `ready` 5 cycles after `valid`:
  - addr/wdata/wstrb are stable throughout;
  - `mem_valid` falls the cycle after `ready`;
  - the next `mem_valid` comes at least 1 cycle later.
- `start` pulsed mid-load (byte 12): ignored, and the load completes normally. `start` after `done`: `done` clears and a new load begins.
- `LOGIC_LOADER_CHECKSUM_EN`: 40 bytes of 0x01 plus checksum 0x00 → `err`=0; checksum 0x5A → `err`=1, `done`=1.
- `resetn` asserted while `mem_valid`=1 at byte 20: all outputs return to reset values immediately; a new `start` loads all 40 from gate 0 reg 0.

Source files
------------

// File: rtl/logic_loader_pkg.sv
// Shared types and constants for the logic-config loader: FSM states, bus request record, address layout.
// Latency: n/a (declarations only). Backpressure: n/a.
package logic_loader_pkg;

    localparam int NUM_GATES     = 8;
    localparam int REGS_PER_GATE = 5;

    localparam logic [3:0] WSTRB_BYTE0 = 4'b0001;
    localparam logic [3:0] WSTRB_READ  = 4'b0000;

    // Gate index lands in the upper address byte, register index in the lower.
    localparam int GATE_LSB = 8;
    localparam int REG_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_BYTE,
        ST_WRITE,
        ST_CHECK,
        ST_READ,
        ST_FINISH
    } state_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    function automatic logic [15:0] cfg_offset(input logic [2:0] gate, input logic [2:0] regi);
        cfg_offset = (16'(gate) << GATE_LSB) | (16'(regi) << REG_LSB);
    endfunction

endpackage

// File: rtl/mem_initiator.sv
// Single-outstanding valid/ready bus initiator; holds addr/wdata/wstrb stable until ready is sampled.
// Latency: req_vld -> mem_valid next cycle; cpl_vld is combinational on the cycle mem_ready is sampled.
// Backpressure: waits indefinitely for mem_ready; always idles one cycle after completion before a new request.
module mem_initiator
    import logic_loader_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_vld,
    input  mem_req_t    req_dat,
    output logic        cpl_vld,
    output logic [31:0] cpl_dat,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    logic     valid_q, valid_d;
    mem_req_t req_q, req_d;

    // A request is only loaded while the bus is idle, so the cycle after a
    // completion always shows valid low even if a new request is pending.
    always_comb begin
        valid_d = valid_q;
        req_d   = req_q;
        if (valid_q) begin
            if (mem_ready) begin
                valid_d = 1'b0;
            end
        end else if (req_vld) begin
            valid_d = 1'b1;
            req_d   = req_dat;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            req_q   <= '0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    assign cpl_vld   = valid_q && mem_ready;
    assign cpl_dat   = mem_rdata;
    assign mem_valid = valid_q;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign mem_wstrb = req_q.wstrb;

endmodule

// File: rtl/logic_config_loader.sv
// Streams 40 config bytes into the logic peripheral as byte writes, then reads back its status word.
// Latency: byte accepted at T -> mem_valid at T+1; 3 cycles/byte with a 1-cycle responder. Optional LOGIC_LOADER_CHECKSUM_EN adds an XOR check byte.
// Backpressure: s_ready is low while a write is outstanding; responder latency is unbounded, no timeout.
module logic_config_loader #(
    parameter logic [15:0] BASE_ADDR     = 16'h0000,
    parameter int          NUM_GATES     = logic_loader_pkg::NUM_GATES,
    parameter int          REGS_PER_GATE = logic_loader_pkg::REGS_PER_GATE
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] snapshot
);

    import logic_loader_pkg::*;

    localparam logic [2:0] LAST_GATE = 3'(NUM_GATES - 1);
    localparam logic [2:0] LAST_REG  = 3'(REGS_PER_GATE - 1);

    state_e      state_q, state_d;
    logic [2:0]  gate_q, gate_d;
    logic [2:0]  reg_idx_q, reg_idx_d;
    logic        s_ready_q, s_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] snapshot_q, snapshot_d;

    logic        s_hs;
    logic        req_vld;
    mem_req_t    req_dat;
    mem_req_t    wr_req;
    mem_req_t    rd_req;
    logic        cpl_vld;
    logic [31:0] cpl_dat;

`ifdef LOGIC_LOADER_CHECKSUM_EN
    logic [7:0]  xor_q, xor_d;
    logic        err_q, err_d;
`endif

    assign s_hs = s_valid && s_ready_q;

    always_comb begin
        wr_req       = '0;
        wr_req.addr  = BASE_ADDR + cfg_offset(gate_q, reg_idx_q);
        wr_req.wdata = {24'h0, s_data};
        wr_req.wstrb = WSTRB_BYTE0;
        rd_req       = '0;
        rd_req.addr  = BASE_ADDR;
        rd_req.wstrb = WSTRB_READ;
    end

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        reg_idx_d  = reg_idx_q;
        done_d     = done_q;
        snapshot_d = snapshot_q;
        req_vld    = 1'b0;
        req_dat    = wr_req;
`ifdef LOGIC_LOADER_CHECKSUM_EN
        xor_d      = xor_q;
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_GET_BYTE;
                    gate_d    = 3'd0;
                    reg_idx_d = 3'd0;
                    done_d    = 1'b0;
`ifdef LOGIC_LOADER_CHECKSUM_EN
                    xor_d     = 8'h00;
                    err_d     = 1'b0;
`endif
                end
            end
            // The write is launched on the same edge the byte is taken, so the
            // byte never needs a holding register of its own.
            ST_GET_BYTE: begin
                if (s_hs) begin
                    req_vld = 1'b1;
                    state_d = ST_WRITE;
`ifdef LOGIC_LOADER_CHECKSUM_EN
                    xor_d   = xor_q ^ s_data;
`endif
                end
            end
            ST_WRITE: begin
                if (cpl_vld) begin
                    state_d = ST_GET_BYTE;
                    if (reg_idx_q == LAST_REG) begin
                        reg_idx_d = 3'd0;
                        if (gate_q == LAST_GATE) begin
`ifdef LOGIC_LOADER_CHECKSUM_EN
                            state_d = ST_CHECK;
`else
                            state_d = ST_READ;
`endif
                        end else begin
                            gate_d = gate_q + 3'd1;
                        end
                    end else begin
                        reg_idx_d = reg_idx_q + 3'd1;
                    end
                end
            end
`ifdef LOGIC_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                req_dat = rd_req;
                if (s_hs) begin
                    req_vld = 1'b1;
                    state_d = ST_READ;
                    if (s_data != xor_q) begin
                        err_d = 1'b1;
                    end
                end
            end
`endif
            // Entered straight from a write completion: the request is raised
            // only once the bus has shown its idle cycle.
            ST_READ: begin
                req_dat = rd_req;
                if (!mem_valid) begin
                    req_vld = 1'b1;
                end
                if (cpl_vld) begin
                    snapshot_d = cpl_dat;
                    state_d    = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        s_ready_d = (state_d == ST_GET_BYTE) || (state_d == ST_CHECK);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            gate_q     <= 3'd0;
            reg_idx_q  <= 3'd0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            snapshot_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            reg_idx_q  <= reg_idx_d;
            s_ready_q  <= s_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            snapshot_q <= snapshot_d;
        end
    end

`ifdef LOGIC_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            xor_q <= 8'h00;
            err_q <= 1'b0;
        end else begin
            xor_q <= xor_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    mem_initiator u_mem_initiator (
        .clk       (clk),
        .resetn    (resetn),
        .req_vld   (req_vld),
        .req_dat   (req_dat),
        .cpl_vld   (cpl_vld),
        .cpl_dat   (cpl_dat),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    assign s_ready  = s_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign snapshot = snapshot_q;

endmodule
